// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory responder: word-array backing store with independent write and read FSMs,
// INCR-only full-width bursts and a fixed read latency between AR handshake and the first R beat.
module axi4_mem_responder #(
  parameter int unsigned axi_id_width_p   = 6,
  parameter int unsigned axi_addr_width_p = 64,
  parameter int unsigned axi_data_width_p = 512,
  parameter int unsigned mem_els_p        = 1024,
  parameter int unsigned rd_latency_p     = 4,
  localparam int unsigned mosi_width_lp   = 2 * (axi_id_width_p + axi_addr_width_p + 30)
                                            + axi_data_width_p + axi_data_width_p / 8 + 4,
  localparam int unsigned miso_width_lp   = 2 * axi_id_width_p + axi_data_width_p + 10
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [mosi_width_lp-1:0] s_axi4_bus_i,
  output logic [miso_width_lp-1:0] s_axi4_bus_o,
  output logic                     err_o
);

  localparam int unsigned strb_lp   = axi_data_width_p / 8;
  localparam int unsigned off_lp    = $clog2(strb_lp);
  localparam int unsigned idx_w_lp  = $clog2(mem_els_p);
  localparam int unsigned dly_w_lp  = $clog2(rd_latency_p + 2);

  typedef struct packed {
    logic [axi_id_width_p-1:0]   awid;
    logic [axi_addr_width_p-1:0] awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awregion;
    logic [3:0]                  awqos;
    logic                        awvalid;
    logic [axi_data_width_p-1:0] wdata;
    logic [strb_lp-1:0]          wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [axi_id_width_p-1:0]   arid;
    logic [axi_addr_width_p-1:0] araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arregion;
    logic [3:0]                  arqos;
    logic                        arvalid;
    logic                        rready;
  } mosi_s;

  typedef struct packed {
    logic                        awready;
    logic                        wready;
    logic [axi_id_width_p-1:0]   bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        arready;
    logic [axi_id_width_p-1:0]   rid;
    logic [axi_data_width_p-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
  } miso_s;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

  mosi_s bus_in;
  miso_s bus_out;
  assign bus_in       = s_axi4_bus_i;
  assign s_axi4_bus_o = bus_out;

  // Size, burst, cache etc. and high address bits are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^bus_in;

  logic [axi_data_width_p-1:0] mem [mem_els_p];

  w_state_e              w_state_q, w_state_d;
  logic [axi_id_width_p-1:0] w_id_q, w_id_d;
  logic [idx_w_lp-1:0]   w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  err_q, err_d;

  r_state_e              r_state_q, r_state_d;
  logic [axi_id_width_p-1:0] r_id_q, r_id_d;
  logic [idx_w_lp-1:0]   r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [dly_w_lp-1:0]   r_dly_q, r_dly_d;

  logic awready, wready, bvalid, arready, rvalid, rlast, mem_we;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      err_q     <= 1'b0;
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_dly_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      err_q     <= err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_dly_q   <= r_dly_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    err_d     = err_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready = 1'b1;
        if (bus_in.awvalid) begin
          w_id_d    = bus_in.awid;
          w_idx_d   = bus_in.awaddr[off_lp +: idx_w_lp];
          w_len_d   = bus_in.awlen;
          w_cnt_d   = '0;
          w_state_d = WData;
        end
      end
      WData: begin
        wready = 1'b1;
        if (bus_in.wvalid) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          // Burst length comes from awlen; wlast is only checked for consistency.
          if (bus_in.wlast != (w_cnt_q == w_len_q)) err_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = WResp;
        end
      end
      WResp: begin
        bvalid = 1'b1;
        if (bus_in.bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < strb_lp; b++) begin
        if (bus_in.wstrb[b]) mem[w_idx_q][b*8 +: 8] <= bus_in.wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_dly_d   = r_dly_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        arready = 1'b1;
        if (bus_in.arvalid) begin
          r_id_d    = bus_in.arid;
          r_idx_d   = bus_in.araddr[off_lp +: idx_w_lp];
          r_len_d   = bus_in.arlen;
          r_cnt_d   = '0;
          r_dly_d   = dly_w_lp'(rd_latency_p);
          r_state_d = (rd_latency_p == 0) ? RData : RWait;
        end
      end
      RWait: begin
        r_dly_d = r_dly_q - 1'b1;
        if (r_dly_q == dly_w_lp'(1)) r_state_d = RData;
      end
      RData: begin
        rvalid = 1'b1;
        rlast  = (r_cnt_q == r_len_q);
        if (bus_in.rready) begin
          r_idx_d = r_idx_q + 1'b1;
          r_cnt_d = r_cnt_q + 8'd1;
          if (rlast) r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    bus_out         = '0;
    bus_out.awready = awready & ~reset_i;
    bus_out.wready  = wready & ~reset_i;
    bus_out.bid     = w_id_q;
    bus_out.bresp   = 2'b00;
    bus_out.bvalid  = bvalid & ~reset_i;
    bus_out.arready = arready & ~reset_i;
    bus_out.rid     = r_id_q;
    bus_out.rdata   = mem[r_idx_q];
    bus_out.rresp   = 2'b00;
    bus_out.rlast   = rlast;
    bus_out.rvalid  = rvalid & ~reset_i;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: a byte-merging word model feeds expected B/R beats.
module tb_axi4_mem_responder;

  localparam int IW = 6, AW = 64, DW = 512, SW = DW / 8, ELS = 1024, LAT = 4;
  localparam int MOSI_W = 2 * (IW + AW + 30) + DW + SW + 4;

  typedef logic [DW-1:0] data_t;

  typedef struct packed {
    logic [IW-1:0] awid;   logic [AW-1:0] awaddr; logic [7:0] awlen;  logic [2:0] awsize;
    logic [1:0] awburst;   logic awlock;  logic [3:0] awcache; logic [2:0] awprot;
    logic [3:0] awregion;  logic [3:0] awqos; logic awvalid;
    data_t wdata; logic [SW-1:0] wstrb; logic wlast; logic wvalid; logic bready;
    logic [IW-1:0] arid;   logic [AW-1:0] araddr; logic [7:0] arlen;  logic [2:0] arsize;
    logic [1:0] arburst;   logic arlock;  logic [3:0] arcache; logic [2:0] arprot;
    logic [3:0] arregion;  logic [3:0] arqos; logic arvalid; logic rready;
  } mosi_s;

  typedef struct packed {
    logic awready; logic wready; logic [IW-1:0] bid; logic [1:0] bresp; logic bvalid;
    logic arready; logic [IW-1:0] rid; data_t rdata; logic [1:0] rresp; logic rlast;
    logic rvalid;
  } miso_s;

  typedef struct packed {
    data_t         data;
    logic [IW-1:0] id;
    logic          last;
  } rexp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  mosi_s m;
  miso_s s;
  logic  err;

  always #5 clk = ~clk;

  axi4_mem_responder #(
    .axi_id_width_p  (IW),
    .axi_addr_width_p(AW),
    .axi_data_width_p(DW),
    .mem_els_p       (ELS),
    .rd_latency_p    (LAT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .s_axi4_bus_i(m),
    .s_axi4_bus_o(s),
    .err_o       (err)
  );

  int nvec = 0;
  int nerr = 0;
  data_t         model [int];
  rexp_t         rq [$];
  logic [IW-1:0] bq [$];
  data_t         wd [16];
  logic [SW-1:0] ws [16];

  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                           input int wlast_at);
    int idx;
    int n;
    data_t w;
    logic [IW-1:0] eid;
    idx = int'(addr[15:6]);
    bq.push_back(id);
    m.awid = id; m.awaddr = addr; m.awlen = 8'(len); m.awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s.awready) break;
      if (++n > 100) begin $display("FAIL aw_timeout got no awready"); $fatal(1); end
    end
    @(posedge clk); #1;
    m.awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      m.wdata = wd[k]; m.wstrb = ws[k]; m.wlast = (k == wlast_at); m.wvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        nvec++;
        if (s.bvalid !== 1'b0) begin
          nerr++;
          $display("FAIL early_bvalid beat %0d: got %b want 0", k, s.bvalid);
        end
        if (s.wready) break;
        if (++n > 100) begin $display("FAIL w_timeout beat %0d no wready", k); $fatal(1); end
      end
      @(posedge clk); #1;
      w = model.exists(idx) ? model[idx] : 'x;
      for (int b = 0; b < SW; b++) if (ws[k][b]) w[b*8 +: 8] = wd[k][b*8 +: 8];
      model[idx] = w;
      idx = (idx + 1) % ELS;
    end
    m.wvalid = 1'b0; m.wlast = 1'b0; m.bready = 1'b1;
    @(negedge clk);
    eid = bq.pop_front();
    nvec++;
    if (s.bvalid !== 1'b1 || s.bid !== eid || s.bresp !== 2'b00) begin
      nerr++;
      $display("FAIL bresp: got bvalid=%b bid=%0d bresp=%0d want 1/%0d/0",
               s.bvalid, s.bid, s.bresp, eid);
    end
    @(posedge clk); #1;
    m.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                          input bit toggle);
    int idx;
    int n;
    bit first;
    rexp_t e;
    idx = int'(addr[15:6]);
    for (int j = 0; j <= len; j++) begin
      e.data = model.exists(idx) ? model[idx] : 'x;
      e.id   = id;
      e.last = (j == len);
      rq.push_back(e);
      idx = (idx + 1) % ELS;
    end
    m.arid = id; m.araddr = addr; m.arlen = 8'(len); m.arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s.arready) break;
      if (++n > 100) begin $display("FAIL ar_timeout got no arready"); $fatal(1); end
    end
    @(posedge clk); #1;
    m.arvalid = 1'b0;
    m.rready  = !toggle;
    n = 0;
    first = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (s.rvalid) begin
        if (first) begin
          nvec++;
          if (n !== LAT + 1) begin
            nerr++;
            $display("FAIL rd_latency: got %0d cycles want %0d", n, LAT + 1);
          end
          first = 1'b0;
        end
        e = rq[0];
        nvec++;
        if (s.rdata !== e.data || s.rid !== e.id || s.rlast !== e.last || s.rresp !== 2'b00) begin
          nerr++;
          $display("FAIL rbeat: got id=%0d last=%b resp=%0d data=%h want id=%0d last=%b data=%h",
                   s.rid, s.rlast, s.rresp, s.rdata[63:0], e.id, e.last, e.data[63:0]);
        end
        if (m.rready) begin
          void'(rq.pop_front());
          if (e.last) begin @(posedge clk); #1; break; end
        end
      end else if (!first) begin
        nvec++;
        nerr++;
        $display("FAIL rvalid_drop: got rvalid=0 mid-burst want 1");
      end
      if (n > 400) begin $display("FAIL r_timeout burst incomplete"); $fatal(1); end
      @(posedge clk); #1;
      if (toggle) m.rready = ~m.rready;
    end
    m.rready = 1'b0;
  endtask

  task automatic test_reset();
    m = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({s.awready, s.wready, s.bvalid, s.arready, s.rvalid, err} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_hold: got aw/w/b/ar/r/err=%b want 000000",
               {s.awready, s.wready, s.bvalid, s.arready, s.rvalid, err});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({s.awready, s.wready, s.bvalid, s.arready, s.rvalid, err} !== 6'b100100) begin
      nerr++;
      $display("FAIL reset_idle: got aw/w/b/ar/r/err=%b want 100100",
               {s.awready, s.wready, s.bvalid, s.arready, s.rvalid, err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    wd[0] = {16{32'hC0DE_0000 ^ 32'($urandom)}};
    ws[0] = '1;
    axi_write(64'h40, 0, 6'd5, 0);
    axi_read(64'h40, 0, 6'd3, 1'b0);
  endtask

  task automatic test_strobe();
    wd[0] = '1; ws[0] = '1;
    axi_write(64'h80, 0, 6'd1, 0);
    wd[0] = '0; ws[0] = SW'(16'h000F);
    axi_write(64'h80, 0, 6'd2, 0);
    axi_read(64'h80, 0, 6'd4, 1'b0);
  endtask

  task automatic test_burst();
    for (int k = 0; k < 16; k++) begin
      wd[k] = {16{32'(k) | 32'hB000_0000}};
      ws[k] = '1;
    end
    axi_write(64'h1000, 15, 6'd7, 15);
    axi_read(64'h1000, 15, 6'd9, 1'b1);
  endtask

  task automatic test_wrap();
    wd[0] = {16{32'hAAAA_0001}}; ws[0] = '1;
    wd[1] = {16{32'hBBBB_0002}}; ws[1] = '1;
    axi_write(64'((ELS - 1) * 64), 1, 6'd11, 1);
    axi_read(64'((ELS - 1) * 64), 1, 6'd12, 1'b0);
    axi_read(64'h0, 0, 6'd13, 1'b0);
  endtask

  task automatic test_wlast_err();
    nvec++;
    if (err !== 1'b0) begin nerr++; $display("FAIL err_pre: got %b want 0", err); end
    for (int k = 0; k < 4; k++) begin wd[k] = {16{32'($urandom)}}; ws[k] = '1; end
    axi_write(64'h2000, 3, 6'd20, 1);
    nvec++;
    if (err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", err); end
    axi_write(64'h3000, 0, 6'd21, 0);
    axi_read(64'h2000, 3, 6'd22, 1'b0);
    nvec++;
    if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    m.arid = 6'd30; m.araddr = 64'h1000; m.arlen = 8'd3; m.arvalid = 1'b1; m.rready = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (s.arready) break;
      if (++n > 100) begin $display("FAIL ar_timeout in reset test"); $fatal(1); end
    end
    @(posedge clk); #1 m.arvalid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (s.rvalid) break;
      if (++n > 100) begin $display("FAIL rvalid_timeout in reset test"); $fatal(1); end
    end
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (s.rvalid !== 1'b0 || s.arready !== 1'b0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_async: got rvalid=%b arready=%b err=%b want 0/0/0",
               s.rvalid, s.arready, err);
    end
    @(posedge clk); #1 rst = 1'b0;
    m.rready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      nvec++;
      if (s.rvalid !== 1'b0 || s.arready !== 1'b1) begin
        nerr++;
        $display("FAIL post_reset cyc %0d: got rvalid=%b arready=%b want 0/1",
                 c, s.rvalid, s.arready);
      end
    end
    @(posedge clk); #1 m.rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_strobe();
    test_burst();
    test_wrap();
    test_wlast_err();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
